// File: rtl/dff_stim_checker.sv
// ---------------------------------------------------------------------------
// dff_stim_checker
//
// Purpose:
//   Self-contained stimulus generator and checker for a single external
//   flip-flop clocked by the same clock. On a start request it drives N_VEC
//   pseudo-random bits (8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, loaded with
//   SEED) onto dut_d. It checks that each bit reappears on dut_q exactly one
//   clock later. It counts mismatches and records the index of the first one.
//
// Ports:
//   clk            single clock, all state changes on its rising edge
//   rst            synchronous active-high reset, wins over start
//   start          one-cycle run request, honoured only in IDLE or DONE
//   dut_d          registered stimulus bit to the flip-flop under test
//   dut_q          flip-flop under test output
//   busy           high while vectors are being driven or checked
//   done           high once a run has finished, until next start/rst
//   pass           valid while done=1, high when no mismatch was seen
//   err_count      saturating mismatch count
//   first_err_idx  vector index of the first mismatch, 8'hFF when none
//
// Timing of one run (S = edge that samples start):
//   Edge S drives vector 0. Edges S+1 .. S+N_VEC-1 drive vectors 1 .. N_VEC-1.
//   The flip-flop under test captures vector k on the edge after it is driven.
//   The checker sees that captured value on the edge after that. So vector k
//   is checked on edge S+k+2. The checker pipeline therefore holds each
//   driven bit one extra stage (expBit_q) before the compare. With this
//   alignment an ideal DFF matches, and a zero-latency (transparent) part
//   shows up as a mismatch. busy stays high for N_VEC+1 cycles, and exactly
//   N_VEC compares happen.
// ---------------------------------------------------------------------------
module dff_stim_checker #(
    parameter int         N_VEC = 32,
    parameter logic [7:0] SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       dut_d,
    input  logic       dut_q,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [7:0] first_err_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] VEC_TOTAL = 8'(N_VEC);
    localparam logic [7:0] NO_ERROR  = 8'hFF;

    state_t     state_q;
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    logic [7:0] seedNext;
    logic [7:0] vecIdx_q;
    logic [7:0] chkIdx_q;
    logic [7:0] chkIdx_d;
    logic       dutD_q;
    logic       drvValid_q;
    logic       expBit_q;
    logic       expValid_q;
    logic [7:0] errCount_q;
    logic [7:0] errCount_d;
    logic [7:0] firstErrIdx_q;
    logic [7:0] firstErrIdx_d;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic       checking;
    logic       mismatch;

    // One Fibonacci shift step. The new bit enters at the bottom, so bit 0 is
    // always the next stimulus bit to drive.
    function automatic logic [7:0] lfsrStep(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Next-state helpers for the generator and the checker. The compare only
    // counts while a run is active and the pipeline holds a valid expected bit.
    // The error counter sticks at 8'hFF instead of wrapping. The first-error
    // index is written only once per run.
    always_comb begin
        lfsr_d        = lfsrStep(lfsr_q);
        seedNext      = lfsrStep(SEED);
        checking      = expValid_q && ((state_q == RUN) || (state_q == DRAIN));
        mismatch      = checking && (dut_q != expBit_q);
        chkIdx_d      = chkIdx_q;
        errCount_d    = errCount_q;
        firstErrIdx_d = firstErrIdx_q;
        if (checking) begin
            chkIdx_d = chkIdx_q + 8'd1;
        end
        if (mismatch) begin
            if (errCount_q != 8'hFF) begin
                errCount_d = errCount_q + 8'd1;
            end
            if (firstErrIdx_q == NO_ERROR) begin
                firstErrIdx_d = chkIdx_q;
            end
        end
    end

    // Control FSM with registered outputs. Reset is checked first, so it wins
    // over start on the same edge. In IDLE and DONE the stimulus pin is parked
    // low and the pipeline is emptied. A start there clears all results and
    // drives the first vector from SEED directly. The LFSR is left one step
    // ahead, ready for vector 1. RUN keeps driving until every vector is out,
    // then moves to DRAIN. DRAIN performs the last compare, while the final
    // driven bit works its way through the external flop and the expected-bit
    // stage. The pass flag is taken from the count including that last compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            lfsr_q        <= SEED;
            vecIdx_q      <= 8'd0;
            chkIdx_q      <= 8'd0;
            dutD_q        <= 1'b0;
            drvValid_q    <= 1'b0;
            expBit_q      <= 1'b0;
            expValid_q    <= 1'b0;
            errCount_q    <= 8'd0;
            firstErrIdx_q <= NO_ERROR;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    dutD_q     <= 1'b0;
                    drvValid_q <= 1'b0;
                    expValid_q <= 1'b0;
                    if (start) begin
                        state_q       <= RUN;
                        lfsr_q        <= seedNext;
                        dutD_q        <= SEED[0];
                        drvValid_q    <= 1'b1;
                        vecIdx_q      <= 8'd1;
                        chkIdx_q      <= 8'd0;
                        errCount_q    <= 8'd0;
                        firstErrIdx_q <= NO_ERROR;
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                        pass_q        <= 1'b0;
                    end
                end

                RUN: begin
                    chkIdx_q      <= chkIdx_d;
                    errCount_q    <= errCount_d;
                    firstErrIdx_q <= firstErrIdx_d;
                    expBit_q      <= dutD_q;
                    expValid_q    <= drvValid_q;
                    if (vecIdx_q != VEC_TOTAL) begin
                        dutD_q     <= lfsr_q[0];
                        drvValid_q <= 1'b1;
                        lfsr_q     <= lfsr_d;
                        vecIdx_q   <= vecIdx_q + 8'd1;
                    end else begin
                        dutD_q     <= 1'b0;
                        drvValid_q <= 1'b0;
                        state_q    <= DRAIN;
                    end
                end

                DRAIN: begin
                    chkIdx_q      <= chkIdx_d;
                    errCount_q    <= errCount_d;
                    firstErrIdx_q <= firstErrIdx_d;
                    dutD_q        <= 1'b0;
                    drvValid_q    <= 1'b0;
                    expValid_q    <= 1'b0;
                    state_q       <= DONE;
                    busy_q        <= 1'b0;
                    done_q        <= 1'b1;
                    pass_q        <= (errCount_d == 8'd0);
                end

                default: begin
                    state_q    <= IDLE;
                    dutD_q     <= 1'b0;
                    drvValid_q <= 1'b0;
                    expValid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    pass_q     <= 1'b0;
                end
            endcase
        end
    end

    assign dut_d         = dutD_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = errCount_q;
    assign first_err_idx = firstErrIdx_q;

endmodule
